// File: rtl/right_shifter_seq.sv
// Multi-cycle right shifter for ASR/ROR: shifts by sc[1:0], then sc[3:2]*4, then sc[4]*16,
// one stage per cycle, using the run/stall handshake shared with the multiplier and divider.
module right_shifter_seq #(
  parameter bit BYPASS_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        md,
  input  logic [31:0] x,
  input  logic [4:0]  sc,
  output logic        stall,
  output logic [31:0] y
);

  typedef enum logic [2:0] {IDLE, S1, S2, S3, DONE} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] t;
  logic [4:0]  c;
  logic        m;
  logic        zero_bypass;

  // Fill comes from the operand itself for a rotate, from the sign bit for ASR.
  function automatic logic [31:0] shr(input logic [31:0] v, input logic [4:0] amt,
                                      input logic rot);
    logic [63:0] w;
    w = {(rot ? v : {32{v[31]}}), v} >> amt;
    return w[31:0];
  endfunction

  assign zero_bypass = BYPASS_ZERO && (sc == 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (run) state_next = zero_bypass ? DONE : S1;
      S1:      state_next = run ? S2 : IDLE;
      S2:      state_next = run ? S3 : IDLE;
      S3:      state_next = run ? DONE : IDLE;
      DONE:    if (!run) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = rst & run & (state != DONE);
  end

  // Dropping run mid-flight leaves y untouched; the partial t is simply abandoned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t <= '0;
      c <= '0;
      m <= 1'b0;
      y <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            t <= x;
            c <= sc;
            m <= md;
            if (zero_bypass) y <= x;
          end
        end
        S1: if (run) t <= shr(t, {3'b000, c[1:0]}, m);
        S2: if (run) t <= shr(t, {1'b0, c[3:2], 2'b00}, m);
        S3: if (run) y <= shr(t, {c[4], 4'b0000}, m);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_right_shifter_seq.sv
// Bench for right_shifter_seq: two instances (bypass on/off) share stimulus and are checked
// every cycle against a cycle-count model plus literal expectations for directed cases.
module tb_right_shifter_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        md = 1'b0;
  logic [31:0] x = '0;
  logic [4:0]  sc = '0;
  logic        stall_b, stall_n;
  logic [31:0] y_b, y_n;

  int checks = 0;
  int errors = 0;

  // model state per instance: 0 idle, 1 busy, 2 done
  int          mode[2] = '{0, 0};
  int          left[2] = '{0, 0};
  logic [31:0] my[2]   = '{32'd0, 32'd0};
  logic [31:0] res[2]  = '{32'd0, 32'd0};

  always #5 clk = ~clk;

  right_shifter_seq #(.BYPASS_ZERO(1'b1)) dut_b (
    .clk(clk), .rst(rst), .run(run), .md(md), .x(x), .sc(sc), .stall(stall_b), .y(y_b)
  );

  right_shifter_seq #(.BYPASS_ZERO(1'b0)) dut_n (
    .clk(clk), .rst(rst), .run(run), .md(md), .x(x), .sc(sc), .stall(stall_n), .y(y_n)
  );

  function automatic logic [31:0] ref_shift(input logic [31:0] v, input int n, input logic rot);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      if (rot) r[i] = v[(i + n) % 32];
      else     r[i] = (i + n < 32) ? v[i + n] : v[31];
    end
    return r;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle compare against the model, then advance the model with the current inputs.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst) begin
          mode[k] = 0;
          my[k] = '0;
        end
        check32(k == 1 ? "model_y_nobyp" : "model_y_byp", k == 1 ? y_n : y_b, my[k]);
        check32(k == 1 ? "model_stall_nobyp" : "model_stall_byp",
                {31'd0, (k == 1 ? stall_n : stall_b)},
                {31'd0, (rst && run && mode[k] != 2)});
        if (rst) begin
          case (mode[k])
            0: if (run) begin
              res[k] = ref_shift(x, int'(sc), md);
              if (k == 0 && sc == 5'd0) begin
                mode[k] = 2;
                my[k] = x;
              end else begin
                mode[k] = 1;
                left[k] = 3;
              end
            end
            1: if (!run) begin
              mode[k] = 0;
            end else begin
              left[k]--;
              if (left[k] == 0) begin
                mode[k] = 2;
                my[k] = res[k];
              end
            end
            default: if (!run) mode[k] = 0;
          endcase
        end
      end
    end
  end

  task automatic wait_done(output int nb, output int nn);
    nb = 0;
    nn = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (stall_b) nb++;
      if (stall_n) nn++;
      if (!stall_b && !stall_n) return;
      cyc();
      x  = $urandom;
      sc = 5'($urandom);
      md = 1'($urandom);
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got stall still high expected low within 40 cycles");
  endtask

  task automatic run_op(input logic [31:0] xv, input logic [4:0] scv, input logic mdv,
                        input logic [31:0] exp_y);
    int nb, nn;
    cyc();
    x = xv; sc = scv; md = mdv; run = 1'b1;
    wait_done(nb, nn);
    check32("y_byp", y_b, exp_y);
    check32("y_nobyp", y_n, exp_y);
    check32("stall_cycles_byp", nb, (scv == 5'd0) ? 32'd1 : 32'd4);
    check32("stall_cycles_nobyp", nn, 32'd4);
    $display("op %s x=%08h sc=%0d y_byp=%08h y_nobyp=%08h stalls=%0d/%0d",
             mdv ? "ROR" : "ASR", xv, scv, y_b, y_n, nb, nn);
    cyc();
    run = 1'b0;
  endtask

  initial begin
    int nb, nn;
    logic [31:0] rx;

    // reset with run high: stall must stay low
    run = 1'b1;
    cyc();
    cyc();
    check32("reset_y", y_b, 32'd0);
    check32("reset_stall", {31'd0, stall_n}, 32'd0);
    run = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    run_op(32'h8000_0000, 5'd4,  1'b0, 32'hF800_0000);
    run_op(32'h1234_5678, 5'd8,  1'b1, 32'h7812_3456);
    run_op(32'h1234_5678, 5'd16, 1'b1, 32'h5678_1234);
    run_op(32'h0000_0001, 5'd1,  1'b1, 32'h8000_0000);
    run_op(32'h7FFF_FFFF, 5'd31, 1'b0, 32'h0000_0000);
    run_op(32'hFFFF_FFF0, 5'd31, 1'b0, 32'hFFFF_FFFF);
    run_op(32'h8000_0001, 5'd31, 1'b1, 32'h0000_0003);
    run_op(32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF);

    // abort in S2: y keeps the previous result
    cyc();
    x = 32'h8000_0000; sc = 5'd3; md = 1'b0; run = 1'b1;
    cyc();
    cyc();
    run = 1'b0;
    @(negedge clk);
    check32("abort_stall", {31'd0, stall_b | stall_n}, 32'd0);
    cyc();
    @(negedge clk);
    check32("abort_y_byp", y_b, 32'hDEAD_BEEF);
    check32("abort_y_nobyp", y_n, 32'hDEAD_BEEF);
    $display("op ASR aborted in S2 y_byp=%08h y_nobyp=%08h", y_b, y_n);
    run_op(32'hF000_0000, 5'd4, 1'b1, 32'h0F00_0000);

    // async reset while in S3, run held high through deassertion
    cyc();
    x = 32'hCAFE_F00D; sc = 5'd5; md = 1'b1; run = 1'b1;
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    check32("rst_mid_y_byp", y_b, 32'd0);
    check32("rst_mid_y_nobyp", y_n, 32'd0);
    check32("rst_mid_stall", {31'd0, stall_b | stall_n}, 32'd0);
    cyc();
    rst = 1'b1;
    x = 32'h1234_5678; sc = 5'd4; md = 1'b1;
    wait_done(nb, nn);
    check32("post_rst_y", y_n, 32'h8123_4567);
    check32("post_rst_stalls", nn, 32'd4);
    $display("op ROR after reset y_byp=%08h y_nobyp=%08h stalls=%0d/%0d", y_b, y_n, nb, nn);
    cyc();
    run = 1'b0;

    // sweep every count in both modes with random operands
    for (int s = 0; s < 32; s++) begin
      for (int mm = 0; mm < 2; mm++) begin
        rx = $urandom;
        run_op(rx, 5'(s), 1'(mm), ref_shift(rx, s, 1'(mm)));
      end
    end

    cyc();
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
